// File: rtl/multi_cmos_pkg.sv
// Shared encodings for the multi-channel CMOS test-pattern source: modes, FSM states, bar colours.
// Latency: none, types and constants only.
// Backpressure: none, no datapath here.
package multi_cmos_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gen_state_e;

  // Checker squares are 2^CHECK_SHIFT pixels on a side.
  localparam int CHECK_SHIFT = 5;

  // Bar colour as {R,G,B} full/zero flags, left to right on screen.
  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111; // white
      3'd1:    return 3'b110; // yellow
      3'd2:    return 3'b011; // cyan
      3'd3:    return 3'b010; // green
      3'd4:    return 3'b101; // magenta
      3'd5:    return 3'b100; // red
      3'd6:    return 3'b001; // blue
      default: return 3'b000; // black
    endcase
  endfunction

endpackage

// File: rtl/cmos_pattern_pixel.sv
// Per-channel pixel renderer: wraps x+offset into the line, then picks bars/gradient/checker/solid.
// Latency: 1 clock from counter-derived x/y/active to pix_dat.
// Backpressure: none, free-running source; pix_dat is 0 whenever active is low.
module cmos_pattern_pixel
  import multi_cmos_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int DATA_W    = 24,
  parameter int POS_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic [POS_W-1:0]  x,
  input  logic [POS_W-1:0]  y,
  input  logic [POS_W-1:0]  x_offset,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] solid_color,
  output logic [DATA_W-1:0] pix_dat
);

  localparam int C = DATA_W / 3;
  localparam logic [POS_W:0] HDISP_V = (POS_W+1)'(IMG_HDISP);
  localparam logic [POS_W:0] BAR_V   = (POS_W+1)'(IMG_HDISP / 8);

  logic [POS_W:0]    px_sum;
  logic [POS_W:0]    px;
  logic [2:0]        flags;
  logic              chk;
  logic [DATA_W-1:0] pix_c;

  // Shift the pattern by the channel offset, wrap once, then render the selected pattern.
  always_comb begin
    px_sum = {1'b0, x} + {1'b0, x_offset};
    px     = (px_sum >= HDISP_V) ? (px_sum - HDISP_V) : px_sum;
    flags  = bar_flags(3'(px / BAR_V));
    chk    = 1'(px >> CHECK_SHIFT) ^ 1'(y >> CHECK_SHIFT);
    pix_c  = '0;
    case (mode_e'(mode))
      MODE_BARS:  pix_c = {{C{flags[2]}}, {C{flags[1]}}, {C{flags[0]}}};
      MODE_GRAD:  pix_c = {C'(px), C'(y), C'({1'b0, px} + {2'b0, y})};
      MODE_CHECK: pix_c = chk ? '1 : '0;
      MODE_SOLID: pix_c = solid_color;
      default:    pix_c = '0;
    endcase
  end

  // Register the pixel so it lines up with the registered timing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_dat <= '0;
    end else begin
      pix_dat <= active ? pix_c : '0;
    end
  end

endmodule

// File: rtl/multi_cmos_pattern_gen.sv
// CMOS-style video source: one shared vsync/href/clken/x/y grid, CH_NUM offset test-pattern streams.
// Latency: outputs lag the slot counters by 1 clock; first frame_start 2 clocks after enable in IDLE.
// Backpressure: none; frames run back-to-back while enable is high, a started frame always completes.
module multi_cmos_pattern_gen
  import multi_cmos_pkg::*;
#(
  parameter int IMG_HDISP   = 640,
  parameter int IMG_VDISP   = 480,
  parameter int H_BLANK     = 160,
  parameter int V_BLANK     = 45,
  parameter int VSYNC_LINES = 2,
  parameter int CLKEN_DIV   = 1,
  parameter int DATA_W      = 24,
  parameter int CH_NUM      = 2,
  parameter int POS_W       = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [DATA_W-1:0]        solid_color,
  input  logic [CH_NUM*POS_W-1:0]  ch_x_offset,
  output logic                     frame_start,
  output logic                     cmos_vsync,
  output logic                     cmos_href,
  output logic                     cmos_clken,
  output logic [CH_NUM*DATA_W-1:0] cmos_data,
  output logic [POS_W-1:0]         cmos_x_pos,
  output logic [POS_W-1:0]         cmos_y_pos,
  output logic [15:0]              frame_cnt
);

  localparam int H_TOTAL = IMG_HDISP + H_BLANK;
  localparam int V_TOTAL = IMG_VDISP + V_BLANK;
  localparam int DIV_W   = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKEN_DIV - 1);
  localparam logic [HC_W-1:0]  H_ACT_END  = HC_W'(IMG_HDISP);
  localparam logic [HC_W-1:0]  H_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_ACT0     = VC_W'(V_BLANK);
  localparam logic [VC_W-1:0]  V_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_SYNC_END = VC_W'(VSYNC_LINES);

  gen_state_e             state;
  logic [DIV_W-1:0]       div_cnt;
  logic [HC_W-1:0]        h_cnt;
  logic [VC_W-1:0]        v_cnt;
  logic [1:0]             mode_sh;
  logic [DATA_W-1:0]      solid_sh;
  logic [CH_NUM*POS_W-1:0] off_sh;

  logic             tick;
  logic             slot_end;
  logic             h_end;
  logic             v_end;
  logic             active;
  logic             first_slot;
  logic [POS_W-1:0] x_c;
  logic [POS_W-1:0] y_c;

  // Decode the current slot: pixel tick, slot/line/frame ends, active window, image coordinates.
  always_comb begin
    tick       = (div_cnt == '0);
    slot_end   = (div_cnt == DIV_LAST);
    h_end      = (h_cnt == H_LAST);
    v_end      = (v_cnt == V_LAST);
    active     = (state == ST_RUN) && (v_cnt >= V_ACT0) && (h_cnt < H_ACT_END);
    first_slot = (state == ST_RUN) && tick && (h_cnt == '0) && (v_cnt == '0);
    x_c        = POS_W'(h_cnt);
    y_c        = POS_W'(v_cnt - V_ACT0);
  end

  // FSM, slot counters, per-frame config shadows and registered timing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_sh     <= '0;
      solid_sh    <= '0;
      off_sh      <= '0;
      frame_start <= 1'b0;
      cmos_vsync  <= 1'b0;
      cmos_href   <= 1'b0;
      cmos_clken  <= 1'b0;
      cmos_x_pos  <= '0;
      cmos_y_pos  <= '0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          div_cnt     <= '0;
          h_cnt       <= '0;
          v_cnt       <= '0;
          frame_start <= 1'b0;
          cmos_vsync  <= 1'b0;
          cmos_href   <= 1'b0;
          cmos_clken  <= 1'b0;
          cmos_x_pos  <= '0;
          cmos_y_pos  <= '0;
          frame_cnt   <= '0;
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          frame_start <= first_slot;
          cmos_vsync  <= (v_cnt < V_SYNC_END);
          cmos_href   <= active;
          cmos_clken  <= active & tick;
          cmos_x_pos  <= active ? x_c : '0;
          cmos_y_pos  <= active ? y_c : '0;
          // Config is frozen for the whole frame from its very first slot.
          if (first_slot) begin
            mode_sh  <= mode;
            solid_sh <= solid_color;
            off_sh   <= ch_x_offset;
          end
          div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
          if (slot_end) begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            // Only a frame boundary may stop the generator.
            if (h_end && v_end) begin
              frame_cnt <= frame_cnt + 16'd1;
              if (!enable) state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    cmos_pattern_pixel #(
      .IMG_HDISP (IMG_HDISP),
      .DATA_W    (DATA_W),
      .POS_W     (POS_W)
    ) u_pix (
      .clk         (clk),
      .rst_n       (rst_n),
      .active      (active),
      .x           (x_c),
      .y           (y_c),
      .x_offset    (off_sh[ch*POS_W +: POS_W]),
      .mode        (mode_sh),
      .solid_color (solid_sh),
      .pix_dat     (cmos_data[ch*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_multi_cmos_pattern_gen.sv
// Bench for multi_cmos_pattern_gen: random per-frame configs against a pixel reference model.
// Latency: expects pixels 1 clock behind slots, first frame_start 2 clocks after enable.
// Backpressure: none; a scoreboard queue is popped on every cmos_clken.
module tb_multi_cmos_pattern_gen;

  localparam int HD = 16, VD = 4, HB = 4, VB = 3, VS = 1, DIV = 1, DW = 24, CH = 2, PW = 11;
  localparam int HT = HD + HB, VT = VD + VB, FRAME = HT * VT * DIV;
  localparam int NF = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [1:0]       mode;
  logic [DW-1:0]    solid_color;
  logic [CH*PW-1:0] ch_x_offset;
  logic             frame_start, cmos_vsync, cmos_href, cmos_clken;
  logic [CH*DW-1:0] cmos_data;
  logic [PW-1:0]    cmos_x_pos, cmos_y_pos;
  logic [15:0]      frame_cnt;

  multi_cmos_pattern_gen #(
    .IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .V_BLANK(VB), .VSYNC_LINES(VS),
    .CLKEN_DIV(DIV), .DATA_W(DW), .CH_NUM(CH), .POS_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .solid_color(solid_color),
    .ch_x_offset(ch_x_offset), .frame_start(frame_start), .cmos_vsync(cmos_vsync),
    .cmos_href(cmos_href), .cmos_clken(cmos_clken), .cmos_data(cmos_data),
    .cmos_x_pos(cmos_x_pos), .cmos_y_pos(cmos_y_pos), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int x; int y; logic [DW-1:0] d0; logic [DW-1:0] d1; } pix_t;
  typedef struct { int md; logic [DW-1:0] solid; int off0; int off1; } cfg_t;

  pix_t exp_q[$];

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic outs_nonzero();
    return |{frame_start, cmos_vsync, cmos_href, cmos_clken, cmos_data, cmos_x_pos, cmos_y_pos, frame_cnt};
  endfunction

  // Reference pixel straight from the pattern definitions.
  function automatic logic [DW-1:0] model_pix(input cfg_t c, input int off, input int x, input int y);
    int px;
    px = (x + off) % HD;
    case (c.md)
      0: begin
        case (px / (HD / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return {8'(px % 256), 8'(y % 256), 8'((px + y) % 256)};
      2: return ((((px / 32) ^ (y / 32)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return c.solid;
    endcase
  endfunction

  task automatic push_frame(input cfg_t c);
    pix_t p;
    for (int y = 0; y < VD; y++) begin
      for (int x = 0; x < HD; x++) begin
        p.x  = x;
        p.y  = y;
        p.d0 = model_pix(c, c.off0, x, y);
        p.d1 = model_pix(c, c.off1, x, y);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic apply_cfg(input cfg_t c);
    mode        = 2'(c.md);
    solid_color = c.solid;
    ch_x_offset = {PW'(c.off1), PW'(c.off0)};
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.md    = int'($urandom_range(0, 3));
    c.solid = DW'($urandom);
    c.off0  = int'($urandom_range(0, HD - 1));
    c.off1  = int'($urandom_range(0, HD - 1));
    return c;
  endfunction

  task automatic wait_fs(input string nm);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk); #1;
      if (frame_start) found = 1'b1;
    end
    chk(nm, found, 1);
  endtask

  task automatic fs_latency(output int n);
    n = 0;
    for (int i = 1; i <= 8 && n == 0; i++) begin
      @(negedge clk); #1;
      if (frame_start) n = i;
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 2 * FRAME && exp_q.size() != 0; i++) @(negedge clk);
    chk(nm, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every pixel qualifier consumes one expected pixel.
  pix_t sb_e;
  always @(negedge clk) begin
    if (rst_n && cmos_clken) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d, expected none", cmos_x_pos, cmos_y_pos);
      end else begin
        sb_e = exp_q.pop_front();
        if (int'(cmos_x_pos) != sb_e.x || int'(cmos_y_pos) != sb_e.y ||
            cmos_data[DW-1:0] != sb_e.d0 || cmos_data[2*DW-1:DW] != sb_e.d1) begin
          errors++;
          $display("FAIL pixel: got x=%0d y=%0d ch0=%06h ch1=%06h expected x=%0d y=%0d ch0=%06h ch1=%06h",
                   cmos_x_pos, cmos_y_pos, cmos_data[DW-1:0], cmos_data[2*DW-1:DW],
                   sb_e.x, sb_e.y, sb_e.d0, sb_e.d1);
        end
      end
    end
  end

  // Frame-structure monitor: period, sync/href/clken counts, bursts, frame_cnt.
  int cyc = 0, last_fs = 0, vs_n = 0, hr_n = 0, ce_n = 0, bursts = 0, run_len = 0, exp_fc = 0;
  bit have_prev = 1'b0, href_q = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      have_prev = 1'b0;
      href_q    = 1'b0;
    end else begin
      if (have_prev && (cyc - last_fs) > 2 * FRAME) have_prev = 1'b0;
      if (frame_start) begin
        if (have_prev) begin
          chk("frame_period", cyc - last_fs, FRAME);
          chk("vsync_clocks", vs_n, HT * VS);
          chk("href_clocks", hr_n, HD * VD);
          chk("clken_pulses", ce_n, HD * VD);
          chk("href_bursts", bursts, VD);
          exp_fc++;
        end else begin
          exp_fc = 0;
        end
        chk("frame_cnt_at_start", frame_cnt, exp_fc);
        have_prev = 1'b1;
        last_fs   = cyc;
        vs_n = 0; hr_n = 0; ce_n = 0; bursts = 0;
      end
      vs_n += int'(cmos_vsync);
      hr_n += int'(cmos_href);
      ce_n += int'(cmos_clken);
      if (cmos_href && !href_q) begin
        bursts++;
        run_len = 0;
      end
      if (cmos_href) run_len++;
      if (!cmos_href && href_q) chk("href_burst_len", run_len, HD);
      if (cmos_clken != cmos_href) chk("clken_vs_href", cmos_clken, cmos_href);
      if (!cmos_href) chk("blank_data_xy_zero", |{cmos_data, cmos_x_pos, cmos_y_pos}, 0);
      href_q = cmos_href;
    end
  end

  cfg_t cfgs[NF];
  cfg_t rc;
  int   lat;
  int   bad;
  bit   hit;

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = '0; solid_color = '0; ch_x_offset = '0;
    cfgs[0] = '{0, 24'h123456, 0, 2};
    cfgs[1] = '{1, 24'h000000, 3, 7};
    cfgs[2] = '{3, 24'hA5C3E1, 5, 9};
    cfgs[3] = '{2, 24'h5A5A5A, 1, 15};
    for (int i = 4; i < NF; i++) cfgs[i] = rand_cfg();

    repeat (3) @(negedge clk);
    #1 chk("outputs_in_reset", outs_nonzero(), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("idle_before_enable", outs_nonzero(), 0);

    // Back-to-back frames, each config changed mid-way through the previous frame.
    apply_cfg(cfgs[0]);
    push_frame(cfgs[0]);
    enable = 1'b1;
    fs_latency(lat);
    chk("first_frame_start_latency", lat, 2);
    for (int k = 1; k < NF; k++) begin
      repeat ($urandom_range(5, 100)) @(negedge clk);
      #1;
      apply_cfg(cfgs[k]);
      push_frame(cfgs[k]);
      wait_fs("frame_start_seen");
    end

    // Drop enable mid-frame: the frame must finish, then everything goes quiet.
    repeat ($urandom_range(5, 100)) @(negedge clk);
    #1 enable = 1'b0;
    drain("last_frame_complete");
    repeat (10) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (outs_nonzero()) bad++;
    end
    chk("idle_after_disable", bad, 0);

    // Asynchronous reset in the middle of active line 2, then restart.
    rc = rand_cfg();
    apply_cfg(rc);
    push_frame(rc);
    enable = 1'b1;
    wait_fs("frame_start_before_reset");
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      @(negedge clk); #1;
      if (cmos_clken && cmos_x_pos == PW'(5) && cmos_y_pos == PW'(2)) hit = 1'b1;
    end
    chk("reached_line2_pixel5", hit, 1);
    rst_n = 1'b0;
    #1 chk("async_reset_outputs", outs_nonzero(), 0);
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    push_frame(rc);
    fs_latency(lat);
    chk("restart_frame_start_latency", lat, 2);
    chk("frame_cnt_after_reset", frame_cnt, 0);
    repeat ($urandom_range(5, 100)) @(negedge clk);
    #1 enable = 1'b0;
    drain("restart_frame_complete");
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/multi_cmos_pattern_gen.md
# multi_cmos_pattern_gen

Synthesizable, parametrised CMOS-style video source that drives CH_NUM pixel streams on one shared timing grid (vsync/href/clken/x/y), for bring-up and regression of the stitching pipeline without BMP-file cameras. Each channel renders a selectable test pattern with its own horizontal offset, emulating overlapping camera views. It sits in front of the stitching core, in place of the simulation camera models.

## Interface
- IMG_HDISP, 640, active pixels per line (multiple of 8)
- IMG_VDISP, 480, active lines per frame
- H_BLANK, 160, blank pixel slots after each line's active part
- V_BLANK, 45, blank lines at frame start (≥ VSYNC_LINES+1)
- VSYNC_LINES, 2, lines with vsync high at frame start
- CLKEN_DIV, 1, clocks per pixel slot (≥1)
- DATA_W, 24, bits per pixel (multiple of 3; C = DATA_W/3 per component, R at MSBs)
- CH_NUM, 2, channel count
- POS_W, 11, width of position/offset fields
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run; frames start only while high
- mode  in  2  0 colour bars, 1 gradient, 2 checkerboard, 3 solid
- solid_color  in  DATA_W  colour for mode 3
- ch_x_offset  in  CH_NUM*POS_W  per-channel pattern offset, ch0 at LSBs; legal < IMG_HDISP
- frame_start  out  1  one-clock pulse on the first slot of each frame
- cmos_vsync  out  1  active-high frame sync
- cmos_href  out  1  high on active pixels of active lines
- cmos_clken  out  1  pixel qualifier
- cmos_data  out  CH_NUM*DATA_W  pixel per channel, ch0 at LSBs
- cmos_x_pos  out  POS_W  active x, 0 outside active
- cmos_y_pos  out  POS_W  active y, 0 outside active
- frame_cnt  out  16  completed frames, wraps

## Operation
- Divider counts 0..CLKEN_DIV-1; tick at count 0. h_cnt 0..H_TOTAL-1 (H_TOTAL=IMG_HDISP+H_BLANK), v_cnt 0..V_TOTAL-1 (V_TOTAL=IMG_VDISP+V_BLANK) advance on tick.
- State machine IDLE / RUN. IDLE: counters held 0, all outputs 0; enters RUN when enable=1. RUN: leaves to IDLE only at frame wrap (last slot of v_cnt=V_TOTAL-1) with enable=0 — a frame is never truncated.
- vsync = v_cnt < VSYNC_LINES. active = v_cnt ≥ V_BLANK and h_cnt < IMG_HDISP. href = active; clken = active & tick. x = h_cnt, y = v_cnt − V_BLANK.
- mode, solid_color, ch_x_offset sampled into shadow registers at frame start slot (h=0,v=0 tick); mid-frame changes take effect next frame.
- Per channel px = x + off; if px ≥ IMG_HDISP subtract IMG_HDISP once (illegal offsets give that result, unspecified image).
- Bars: index = px/(IMG_HDISP/8): white, yellow, cyan, green, magenta, red, blue, black (component full = all-ones C bits).
- Gradient: R = px mod 2^C, G = y mod 2^C, B = (px+y) mod 2^C.
- Checker: ((px>>5) ^ (y>>5)) & 1 ? all-ones : all-zeros.
- Solid: solid_color on every active pixel. cmos_data = 0 when not active.
- frame_cnt increments at each completed frame wrap.

## Timing
- All outputs registered; reset value 0 for every output and counter, state IDLE.
- Outputs lag counter state by one clock; first frame_start pulse 2 clocks after enable rises in IDLE (1 to enter RUN, 1 register).
- Frame length exactly H_TOTAL*V_TOTAL*CLKEN_DIV clocks; back-to-back frames have no gap while enable stays high.
- With CLKEN_DIV>1 href stays high for the whole slot; clken pulses on its first clock; data/x/y stable across the slot.
- Reset mid-frame: outputs 0 immediately (async), restart from IDLE.

## Structure
- Package multi_cmos_pkg: mode encodings, bar colour table (8 entries × 3 components as full/zero flags), checker shift (5).
- Sub-module cmos_pattern_pixel: registered per-channel pixel generator (px wrap + pattern mux), instantiated CH_NUM times via generate; top holds divider, counters, FSM, shadow registers.

## Test plan
Bench params: IMG_HDISP 16, IMG_VDISP 4, H_BLANK 4, V_BLANK 3, VSYNC_LINES 1, CLKEN_DIV 1, DATA_W 24, CH_NUM 2.
- enable=1 after reset → frame_start every 140 clocks; vsync high 20 clocks; 4 href bursts of 16 clocks each; 64 clken per frame; frame_cnt 1 after first frame.
- mode 0, offsets 0/2 → ch0 x=0..1 0xFFFFFF, x=2 0xFFFF00; ch1 x=0 0xFFFF00, x=14 0x000000 for ch0 x=14, ch1 x=14 0xFFFFFF (wrap).
- mode 1, offset ch0=3 → at x=15,y=2: R=0x02, G=0x02, B=0x04.
- mode changed 3→2 mid-frame → solid_color until frame end, checker (all 16 x at y=0 → all-ones? no: px<32 → 0x000000) from next frame_start.
- enable dropped mid-frame → current frame completes (all 64 clken), then all outputs 0, no further frame_start.
- rst_n low at line 2 pixel 5 → all outputs 0 same clock; after release with enable=1, frame_start 2 clocks later, frame_cnt=0.
